// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory interface and a
// table of 2-bit saturating counters that steers fetch for beq/bne branches.
module fetch_stage #(
   parameter int          BHT_ENTRIES = 16,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pcWr,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] ir,
   output logic [31:0] pc,
   output logic        prediction,
   input  logic        resolve_valid,
   input  logic [31:0] resolve_pc,
   input  logic        resolve_taken,
   input  logic [31:0] resolve_target,
   input  logic        resolve_pred,
   output logic        flush
);

   localparam int IDX = $clog2(BHT_ENTRIES);

   logic [31:0]        pc_reg;
   logic [1:0]         bht [BHT_ENTRIES];
   logic [IDX-1:0]     fetch_idx;
   logic [IDX-1:0]     resolve_idx;
   logic               is_branch;
   logic               mispredict;
   logic signed [31:0] branch_offset;
   logic [31:0]        pc_plus4;
   logic [31:0]        pred_target;
   logic [31:0]        next_pc;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      if (taken)
         sat_update = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
      else
         sat_update = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
   endfunction

   assign fetch_idx     = pc_reg[IDX+1:2];
   assign resolve_idx   = resolve_pc[IDX+1:2];
   assign is_branch     = (imem_data[31:26] == 6'h04) || (imem_data[31:26] == 6'h05);
   assign branch_offset = {{14{imem_data[15]}}, imem_data[15:0], 2'b00};
   assign pc_plus4      = pc_reg + 32'd4;
   assign pred_target   = pc_plus4 + branch_offset;
   assign mispredict    = resolve_valid && (resolve_taken != resolve_pred);

   assign imem_addr  = pc_reg;
   assign ir         = imem_data;
   assign pc         = pc_plus4;
   assign prediction = is_branch && bht[fetch_idx][1];
   assign flush      = mispredict && reset;

   // A mispredict redirect wins over a stall; a stall wins over prediction.
   always_comb begin
      next_pc = pc_plus4;
      if (mispredict)
         next_pc = resolve_taken ? resolve_target : resolve_pc + 32'd4;
      else if (!pcWr)
         next_pc = pc_reg;
      else if (prediction)
         next_pc = pred_target;
   end

   // The fetch above reads the pre-update counter; the write lands on this edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_reg <= RESET_PC;
         for (int i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= 2'b01;
      end else begin
         pc_reg <= next_pc;
         if (resolve_valid)
            bht[resolve_idx] <= sat_update(bht[resolve_idx], resolve_taken);
      end
   end

endmodule
